// File: rtl/ibex_rf_pkg.sv
//============================================================================
// Module      : ibex_rf_pkg
// Description : Shared constants, types and helpers for the multi-port
//               integer register file and its pending-write scoreboard.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

package ibex_rf_pkg;

    localparam int RF_ADDR_W = 5;
    localparam int RF_REGS_I = 32;
    localparam int RF_REGS_E = 16;

    typedef logic [RF_ADDR_W-1:0] rf_addr_t;

    // RV32E only implements x0..x15, so any address with bit 4 set is illegal.
    function automatic logic rf_addr_legal(input rf_addr_t addr, input logic rv32e);
        return ~(rv32e & addr[4]);
    endfunction

endpackage

`default_nettype wire

// File: rtl/ibex_rf_scoreboard.sv
//============================================================================
// Module      : ibex_rf_scoreboard
// Description : One pending bit per register, set when a load is issued and
//               cleared by the LSU writeback. Reports busy per read port.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module ibex_rf_scoreboard
    import ibex_rf_pkg::*;
#(
    parameter int NumRegs      = 32,
    parameter int NumReadPorts = 3,
    parameter int WriteThrough = 1
) (
    input  logic                                   clk_i,
    input  logic                                   rst_ni,
    input  logic                                   set_i,       // already qualified: legal, non-zero
    input  logic [RF_ADDR_W-1:0]                   set_addr_i,
    input  logic                                   clr_i,       // already qualified: legal, non-zero
    input  logic [RF_ADDR_W-1:0]                   clr_addr_i,
    input  logic [NumReadPorts-1:0][RF_ADDR_W-1:0] raddr_i,
    output logic [NumReadPorts-1:0]                busy_o
);

    localparam int IdxW = $clog2(NumRegs);

    logic [NumRegs-1:0] pend_q;
    logic [NumRegs-1:0] pend_d;

    // Next pending state: a new load issue wins over a same-cycle writeback.
    always_comb begin
        pend_d = pend_q;
        for (int r = 1; r < NumRegs; r++) begin
            if (set_i && set_addr_i == RF_ADDR_W'(r)) begin
                pend_d[r] = 1'b1;
            end else if (clr_i && clr_addr_i == RF_ADDR_W'(r)) begin
                pend_d[r] = 1'b0;
            end
        end
        pend_d[0] = 1'b0;
    end

    // Pending bits; reset drops any in-flight load tracking.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    for (genvar p = 0; p < NumReadPorts; p++) begin : g_busy
        logic in_range;
        logic bypass;
        assign in_range  = int'(raddr_i[p]) < NumRegs;
        // With write-through the arriving LSU data is already forwarded, so no stall.
        assign bypass    = (WriteThrough != 0) && clr_i && (clr_addr_i == raddr_i[p]);
        assign busy_o[p] = in_range & pend_q[raddr_i[p][IdxW-1:0]] & ~bypass;
    end

endmodule

`default_nettype wire

// File: rtl/ibex_register_file_mp.sv
//============================================================================
// Module      : ibex_register_file_mp
// Description : Flip-flop RISC-V register file, N read ports, ALU (A) and
//               LSU (B) write ports, optional write-through bypass, pending
//               LSU-write scoreboard and RV32E illegal-address reporting.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module ibex_register_file_mp
    import ibex_rf_pkg::*;
#(
    parameter int DataWidth    = 32,
    parameter int RV32E        = 0,
    parameter int NumReadPorts = 3,
    parameter int WriteThrough = 1
) (
    input  logic                                   clk_i,
    input  logic                                   rst_ni,
    input  logic [NumReadPorts-1:0][4:0]           raddr_i,
    output logic [NumReadPorts-1:0][DataWidth-1:0] rdata_o,
    output logic [NumReadPorts-1:0]                rbusy_o,
    input  logic [4:0]                             waddr_a_i,
    input  logic [DataWidth-1:0]                   wdata_a_i,
    input  logic                                   we_a_i,
    input  logic [4:0]                             waddr_b_i,
    input  logic [DataWidth-1:0]                   wdata_b_i,
    input  logic                                   we_b_i,
    input  logic [4:0]                             pend_addr_i,
    input  logic                                   pend_set_i,
    output logic                                   err_o
);

    localparam logic IsE     = (RV32E != 0);
    localparam int   NumRegs = IsE ? RF_REGS_E : RF_REGS_I;
    localparam int   IdxW    = IsE ? 4 : 5;

    // Qualified enables: illegal addresses and x0 never touch state.
    logic we_a_ok;
    logic we_b_ok;
    logic pend_ok;
    assign we_a_ok = we_a_i & rf_addr_legal(waddr_a_i, IsE) & (waddr_a_i != '0);
    assign we_b_ok = we_b_i & rf_addr_legal(waddr_b_i, IsE) & (waddr_b_i != '0);
    assign pend_ok = pend_set_i & rf_addr_legal(pend_addr_i, IsE) & (pend_addr_i != '0);

    logic [DataWidth-1:0] rf_q    [NumRegs-1:1];
    logic [DataWidth-1:0] rf_view [NumRegs];

    assign rf_view[0] = '0;

    for (genvar r = 1; r < NumRegs; r++) begin : g_regs
        logic hit_a;
        logic hit_b;
        assign hit_a      = we_a_ok && (waddr_a_i == rf_addr_t'(r));
        assign hit_b      = we_b_ok && (waddr_b_i == rf_addr_t'(r));
        assign rf_view[r] = rf_q[r];

        // Register storage; port A wins when both ports target this register.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                rf_q[r] <= '0;
            end else if (hit_a) begin
                rf_q[r] <= wdata_a_i;
            end else if (hit_b) begin
                rf_q[r] <= wdata_b_i;
            end
        end
    end

    logic [NumReadPorts-1:0] rd_bad;

    for (genvar p = 0; p < NumReadPorts; p++) begin : g_rports
        logic                 legal;
        logic [DataWidth-1:0] rd;
        assign legal     = rf_addr_legal(raddr_i[p], IsE);
        assign rd_bad[p] = ~legal;

        // Read mux: x0/illegal first, then same-cycle A, then B, then stored.
        always_comb begin
            rd = rf_view[raddr_i[p][IdxW-1:0]];
            if (!legal || raddr_i[p] == '0) begin
                rd = '0;
            end else if ((WriteThrough != 0) && we_a_ok && waddr_a_i == raddr_i[p]) begin
                rd = wdata_a_i;
            end else if ((WriteThrough != 0) && we_b_ok && waddr_b_i == raddr_i[p]) begin
                rd = wdata_b_i;
            end
        end

        assign rdata_o[p] = rd;
    end

    ibex_rf_scoreboard #(
        .NumRegs      (NumRegs),
        .NumReadPorts (NumReadPorts),
        .WriteThrough (WriteThrough)
    ) u_scoreboard (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .set_i      (pend_ok),
        .set_addr_i (pend_addr_i),
        .clr_i      (we_b_ok),
        .clr_addr_i (waddr_b_i),
        .raddr_i    (raddr_i),
        .busy_o     (rbusy_o)
    );

    logic err_d;
    logic err_q;
    assign err_d = IsE & ((we_a_i     & ~rf_addr_legal(waddr_a_i,   IsE)) |
                          (we_b_i     & ~rf_addr_legal(waddr_b_i,   IsE)) |
                          (pend_set_i & ~rf_addr_legal(pend_addr_i, IsE)) |
                          (|rd_bad));

    // Error pulse registered one cycle after the offending access.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_o = err_q;

endmodule

`default_nettype wire

// File: tb/tb_ibex_register_file_mp.sv
//============================================================================
// Module      : tb_ibex_register_file_mp
// Description : Directed bench for ibex_register_file_mp. Two instances share
//               stimulus: D (RV32I, write-through) and E (RV32E, no bypass).
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_ibex_register_file_mp;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [2:0][4:0]  raddr;
    logic [4:0]       waddr_a, waddr_b, pend_addr;
    logic [31:0]      wdata_a, wdata_b;
    logic             we_a, we_b, pend_set;

    logic [2:0][31:0] rdata_d, rdata_e;
    logic [2:0]       rbusy_d, rbusy_e;
    logic             err_d, err_e;

    always #5 clk = ~clk;

    ibex_register_file_mp #(.DataWidth(32), .RV32E(0), .NumReadPorts(3), .WriteThrough(1)) dut_d (
        .clk_i(clk), .rst_ni(rst_n), .raddr_i(raddr), .rdata_o(rdata_d), .rbusy_o(rbusy_d),
        .waddr_a_i(waddr_a), .wdata_a_i(wdata_a), .we_a_i(we_a),
        .waddr_b_i(waddr_b), .wdata_b_i(wdata_b), .we_b_i(we_b),
        .pend_addr_i(pend_addr), .pend_set_i(pend_set), .err_o(err_d)
    );

    ibex_register_file_mp #(.DataWidth(32), .RV32E(1), .NumReadPorts(3), .WriteThrough(0)) dut_e (
        .clk_i(clk), .rst_ni(rst_n), .raddr_i(raddr), .rdata_o(rdata_e), .rbusy_o(rbusy_e),
        .waddr_a_i(waddr_a), .wdata_a_i(wdata_a), .we_a_i(we_a),
        .waddr_b_i(waddr_b), .wdata_b_i(wdata_b), .we_b_i(we_b),
        .pend_addr_i(pend_addr), .pend_set_i(pend_set), .err_o(err_e)
    );

    typedef struct {
        string       tag;
        int          which;   // 0: dut_d, 1: dut_e
        int          kind;    // 0: rdata, 1: rbusy, 2: err
        int          port;
        logic [31:0] exp;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    logic prev_ill = 1'b0;

    task automatic push(input string tag, input int which, input int kind, input int port, input logic [31:0] v);
        exp_t e;
        e.tag = tag; e.which = which; e.kind = kind; e.port = port; e.exp = v;
        q.push_back(e);
    endtask

    task automatic exp_rd(input string tag, input int port, input logic [31:0] vd, input logic [31:0] ve);
        push({tag, "_d"}, 0, 0, port, vd);
        push({tag, "_e"}, 1, 0, port, ve);
    endtask

    task automatic exp_busy(input string tag, input int port, input logic bd, input logic be);
        push({tag, "_d"}, 0, 1, port, {31'b0, bd});
        push({tag, "_e"}, 1, 1, port, {31'b0, be});
    endtask

    function automatic logic [31:0] observe(input int which, input int kind, input int port);
        logic [31:0] v;
        v = '0;
        case (kind)
            0:       v = (which == 0) ? rdata_d[port] : rdata_e[port];
            1:       v = {31'b0, (which == 0) ? rbusy_d[port] : rbusy_e[port]};
            default: v = {31'b0, (which == 0) ? err_d : err_e};
        endcase
        return v;
    endfunction

    task automatic drain();
        exp_t        e;
        logic [31:0] obs;
        while (q.size() > 0) begin
            e   = q.pop_front();
            obs = observe(e.which, e.kind, e.port);
            total++;
            assert (obs === e.exp)
            else begin
                bad++;
                $error("FAIL %s port=%0d observed=%0h expected=%0h", e.tag, e.port, obs, e.exp);
            end
        end
    endtask

    task automatic begin_step();
        @(negedge clk);
        we_a = 1'b0; we_b = 1'b0; pend_set = 1'b0;
        waddr_a = '0; waddr_b = '0; pend_addr = '0;
        wdata_a = '0; wdata_b = '0; raddr = '0;
    endtask

    // RV32E error expectation: err in this window reflects last step's inputs.
    task automatic end_step();
        logic ill;
        ill = (we_a & waddr_a[4]) | (we_b & waddr_b[4]) | (pend_set & pend_addr[4]);
        for (int p = 0; p < 3; p++) ill = ill | raddr[p][4];
        push("err_d", 0, 2, 0, 32'd0);
        push("err_e", 1, 2, 0, {31'b0, prev_ill});
        prev_ill = ill;
        #1;
        drain();
    endtask

    initial begin
        rst_n = 1'b0;
        we_a = 1'b0; we_b = 1'b0; pend_set = 1'b0;
        waddr_a = '0; waddr_b = '0; pend_addr = '0;
        wdata_a = '0; wdata_b = '0; raddr = '0;

        // Reset state while reset is held
        @(negedge clk);
        @(negedge clk);
        raddr = {5'd3, 5'd2, 5'd1};
        #1;
        for (int p = 0; p < 3; p++) begin
            exp_rd("rst_rd", p, 32'd0, 32'd0);
            exp_busy("rst_busy", p, 1'b0, 1'b0);
        end
        push("rst_err_d", 0, 2, 0, 32'd0);
        push("rst_err_e", 1, 2, 0, 32'd0);
        drain();
        #2 rst_n = 1'b1;
        prev_ill = 1'b0;

        // Sweep every address on all ports
        for (int a = 0; a < 32; a++) begin
            begin_step();
            raddr = {3{5'(a)}};
            for (int p = 0; p < 3; p++) begin
                exp_rd("sweep_rd", p, 32'd0, 32'd0);
                exp_busy("sweep_busy", p, 1'b0, 1'b0);
            end
            end_step();
        end

        // Write-through vs. committed-state read of x5
        begin_step();
        we_a = 1'b1; waddr_a = 5'd5; wdata_a = 32'hDEADBEEF; raddr[0] = 5'd5;
        exp_rd("x5_same", 0, 32'hDEADBEEF, 32'd0);
        end_step();
        begin_step();
        raddr[0] = 5'd5;
        exp_rd("x5_next", 0, 32'hDEADBEEF, 32'hDEADBEEF);
        end_step();

        // Both ports write x7 while pending: A data wins, B clears pending
        begin_step();
        pend_set = 1'b1; pend_addr = 5'd7;
        end_step();
        begin_step();
        we_a = 1'b1; waddr_a = 5'd7; wdata_a = 32'h11;
        we_b = 1'b1; waddr_b = 5'd7; wdata_b = 32'h22;
        raddr[1] = 5'd7;
        exp_rd("ab_same", 1, 32'h11, 32'd0);
        exp_busy("ab_busy", 1, 1'b0, 1'b1);
        end_step();
        begin_step();
        raddr[1] = 5'd7;
        exp_rd("ab_after", 1, 32'h11, 32'h11);
        exp_busy("ab_clr", 1, 1'b0, 1'b0);
        end_step();

        // Load issue then LSU writeback on x9
        begin_step();
        pend_set = 1'b1; pend_addr = 5'd9; raddr[2] = 5'd9;
        exp_busy("p9_issue", 2, 1'b0, 1'b0);
        end_step();
        begin_step();
        raddr[2] = 5'd9;
        exp_busy("p9_pend", 2, 1'b1, 1'b1);
        end_step();
        begin_step();
        we_b = 1'b1; waddr_b = 5'd9; wdata_b = 32'h55; raddr[2] = 5'd9;
        exp_rd("p9_wb_rd", 2, 32'h55, 32'd0);
        exp_busy("p9_wb_busy", 2, 1'b0, 1'b1);
        end_step();
        begin_step();
        raddr[2] = 5'd9;
        exp_rd("p9_done_rd", 2, 32'h55, 32'h55);
        exp_busy("p9_done_busy", 2, 1'b0, 1'b0);
        end_step();

        // Set and clear of x9 in the same cycle: set wins
        begin_step();
        pend_set = 1'b1; pend_addr = 5'd9;
        we_b = 1'b1; waddr_b = 5'd9; wdata_b = 32'h66; raddr[2] = 5'd9;
        exp_rd("sc_rd", 2, 32'h66, 32'h55);
        exp_busy("sc_busy", 2, 1'b0, 1'b0);
        end_step();
        begin_step();
        raddr[2] = 5'd9;
        exp_rd("sc_after_rd", 2, 32'h66, 32'h66);
        exp_busy("sc_after_busy", 2, 1'b1, 1'b1);
        end_step();
        begin_step();
        we_b = 1'b1; waddr_b = 5'd9; wdata_b = 32'h77; raddr[2] = 5'd9;
        exp_rd("sc_wb_rd", 2, 32'h77, 32'h66);
        exp_busy("sc_wb_busy", 2, 1'b0, 1'b1);
        end_step();
        begin_step();
        raddr[2] = 5'd9;
        exp_rd("sc_fin_rd", 2, 32'h77, 32'h77);
        exp_busy("sc_fin_busy", 2, 1'b0, 1'b0);
        end_step();

        // Upper-half addresses: legal for D, ignored (and flagged) for E
        begin_step();
        we_a = 1'b1; waddr_a = 5'd20; wdata_a = 32'h1; raddr[0] = 5'd20; raddr[1] = 5'd4;
        exp_rd("x20_same", 0, 32'h1, 32'd0);
        exp_rd("x4_same", 1, 32'd0, 32'd0);
        end_step();
        begin_step();
        raddr[0] = 5'd20; raddr[1] = 5'd4;
        exp_rd("x20_next", 0, 32'h1, 32'd0);
        exp_rd("x4_alias", 1, 32'd0, 32'd0);
        end_step();
        begin_step();
        we_b = 1'b1; waddr_b = 5'd21; wdata_b = 32'h5;
        pend_set = 1'b1; pend_addr = 5'd25;
        end_step();
        begin_step();
        raddr[0] = 5'd21; raddr[1] = 5'd5; raddr[2] = 5'd9;
        exp_rd("x21_rd", 0, 32'h5, 32'd0);
        exp_rd("x5_alias", 1, 32'hDEADBEEF, 32'hDEADBEEF);
        exp_busy("x9_alias_busy", 2, 1'b0, 1'b0);
        end_step();
        begin_step();
        raddr[1] = 5'd25;
        exp_busy("x25_busy", 1, 1'b1, 1'b0);
        end_step();
        begin_step();
        end_step();

        // Writes and pend_set to x0 have no effect
        begin_step();
        we_a = 1'b1; waddr_a = 5'd0; wdata_a = 32'hFF;
        we_b = 1'b1; waddr_b = 5'd0; wdata_b = 32'hEE;
        pend_set = 1'b1; pend_addr = 5'd0;
        exp_rd("x0_same", 0, 32'd0, 32'd0);
        exp_busy("x0_busy_same", 0, 1'b0, 1'b0);
        end_step();
        begin_step();
        exp_rd("x0_next", 0, 32'd0, 32'd0);
        exp_busy("x0_busy_next", 0, 1'b0, 1'b0);
        end_step();

        // Asynchronous reset mid-operation clears data and scoreboard
        begin_step();
        pend_set = 1'b1; pend_addr = 5'd9;
        end_step();
        @(negedge clk);
        pend_set = 1'b0; raddr = {5'd9, 5'd0, 5'd5};
        #1;
        exp_busy("pre_rst_busy", 2, 1'b1, 1'b1);
        drain();
        rst_n = 1'b0;
        #1;
        exp_rd("mid_rst_rd", 0, 32'd0, 32'd0);
        exp_busy("mid_rst_busy", 2, 1'b0, 1'b0);
        push("mid_rst_err_d", 0, 2, 0, 32'd0);
        push("mid_rst_err_e", 1, 2, 0, 32'd0);
        drain();
        rst_n = 1'b1;
        prev_ill = 1'b0;
        begin_step();
        we_b = 1'b1; waddr_b = 5'd9; wdata_b = 32'h99; raddr[2] = 5'd9;
        exp_rd("post_rst_wb", 2, 32'h99, 32'd0);
        exp_busy("post_rst_busy", 2, 1'b0, 1'b0);
        end_step();
        begin_step();
        raddr[2] = 5'd9;
        exp_rd("post_rst_rd", 2, 32'h99, 32'h99);
        end_step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
